instr_fetch_unit: RTL

- Fetch stage between the byte-wide instruction memory and the CPU decode stage.
- Issues four consecutive byte reads from the PC and assembles a big-endian 32-bit instruction.
- Presents the instruction to decode over a valid/ready handshake.
- Advances the PC by 4, or to a redirect target, and halts cleanly at the end of instruction memory.

---
 rtl/instr_fetch_unit_pkg.sv | 35 +++
 rtl/instr_word_assembler.sv | 39 +++
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types: FSM states, PC check result and the
// alignment/bounds helper used when a new fetch PC is chosen.
package cpu_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        VALID,
        HALT,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        CHK_OK,
        CHK_MISALIGN,
        CHK_OOB
    } chk_t;

    localparam int INSTR_BYTES   = 4;
    localparam int INSTR_MAX_DEF = 128;

    // Misalignment takes priority over the end-of-memory check.
    function automatic chk_t fetch_ok(
        input logic [63:0] pc,
        input logic [63:0] imax
    );
        if (pc[1:0] != 2'b00)
            return CHK_MISALIGN;
        if (pc > imax - 64'(INSTR_BYTES))
            return CHK_OOB;
        return CHK_OK;
    endfunction

endpackage

// File: rtl/instr_word_assembler.sv
// Byte issue counter plus big-endian shift register that builds
// one 32-bit instruction from four byte reads.
module instr_word_assembler
    import cpu_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_issue,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_cnt,
    output logic        o_done,
    output logic [31:0] o_word
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else if (i_clear) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else begin
            if (i_issue)
                r_cnt <= r_cnt + 2'd1;
            if (i_shift)
                r_word <= {r_word[23:0], i_byte};
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = (r_cnt == 2'(INSTR_BYTES - 1));
    assign o_word = r_word;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads four bytes per instruction from byte-wide
// memory and hands big-endian words to decode via valid/ready.
module instr_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int INSTR_MAX = INSTR_MAX_DEF,
    parameter int MEM_AW    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_re,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              halted,
    output logic              error
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_tgt;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              w_go;
    logic              w_issue;
    logic              w_shift;
    logic              w_active;
    logic              w_done;
    logic [1:0]        w_cnt;
    logic [31:0]       w_word;
    chk_t              w_chk;

    assign w_active = (r_state == FETCH) || (r_state == DRAIN)
                   || (r_state == VALID);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_tgt       = r_pc;
        w_go        = 1'b0;
        w_issue     = 1'b0;
        w_shift     = 1'b0;
        w_chk       = CHK_OK;
        if (start) begin
            w_go  = 1'b1;
            w_tgt = start_pc;
        end else if (redirect && w_active) begin
            w_go  = 1'b1;
            w_tgt = redirect_pc;
        end else begin
            unique case (r_state)
                FETCH: begin
                    // Byte k-1 returns while byte k is being issued.
                    w_issue = 1'b1;
                    w_shift = (w_cnt != 2'd0);
                    if (w_done)
                        w_state_nxt = DRAIN;
                end
                DRAIN: begin
                    w_shift     = 1'b1;
                    w_state_nxt = VALID;
                end
                VALID: begin
                    if (instr_ready) begin
                        w_go  = 1'b1;
                        w_tgt = r_pc + ADDR_W'(INSTR_BYTES);
                    end
                end
                default: ;
            endcase
        end
        if (w_go) begin
            w_pc_nxt = w_tgt;
            w_chk    = fetch_ok(64'(w_tgt), 64'(INSTR_MAX));
            unique case (w_chk)
                CHK_MISALIGN: w_state_nxt = ERR;
                CHK_OOB:      w_state_nxt = HALT;
                default:      w_state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_instr_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (r_state == DRAIN)
                r_instr_pc <= r_pc;
        end
    end

    instr_word_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_go),
        .i_issue (w_issue),
        .i_shift (w_shift),
        .i_byte  (mem_rdata),
        .o_cnt   (w_cnt),
        .o_done  (w_done),
        .o_word  (w_word)
    );

    assign mem_re      = (r_state == FETCH);
    assign mem_addr    = MEM_AW'(r_pc + ADDR_W'(w_cnt));
    assign instr       = w_word;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = (r_state == VALID);
    assign halted      = (r_state == HALT);
    assign error       = (r_state == ERR);

endmodule
